fir_l3_input_deserializer: RTL and testbench
============================================

// Module: fir_l3_input_deserializer
// PURPOSE
//  Upstream feeder for the L=3 reduced-parallel pipelined FIR filter top.
//  Accepts one signed sample per handshake from a serial source at 44.1 kHz
//  (sine ROM, ADC capture) and packs three consecutive samples into one
//  3-lane block for data_in_1/2/3.
//  A small block FIFO decouples source stalls from filter-side back-pressure.
// PARAMETERS
//  DATA_IN_WIDTH  16  sample width, two's complement; lanes are the same width
//  BLK_DEPTH      2   output block FIFO depth in blocks; power of two, >= 2
// PORTS
//  clk        in   1              rising-edge clock, single domain
//  reset      in   1              synchronous, active-high reset
//  s_data     in   DATA_IN_WIDTH  serial sample x(n)
//  s_valid    in   1              s_data is valid this cycle
//  s_ready    out  1              block can accept s_data this cycle
//  data_out_1 out  DATA_IN_WIDTH  lane 1 = x(3k), oldest sample of the block
//  data_out_2 out  DATA_IN_WIDTH  lane 2 = x(3k+1)
//  data_out_3 out  DATA_IN_WIDTH  lane 3 = x(3k+2), newest sample of the block
//  out_valid  out  1              block on data_out_1..3 is valid
//  out_ready  in   1              consumer takes the block this cycle
//  flush      in   1              only when DESER_FLUSH_EN is defined
// BEHAVIOUR
//  - Reset: phase=0, FIFO empty, partial-block holding regs=0, out_valid=0,
//    data_out_1..3=0, s_ready=1 on the first cycle after reset deasserts.
//  - Accept rule: a sample is accepted when s_valid & s_ready at the clk edge.
//  - Phase counter 0->1->2->0 advances only on accept. Phase 0 stores to
//    hold1, phase 1 stores to hold2. Phase 2 pushes {hold1,hold2,s_data}
//    into the FIFO; s_data goes direct to lane 3 with no extra register.
//  - s_ready = (phase != 2) | !fifo_full. It is registered-state-only and has
//    no combinational path from out_ready. The first two samples of a block
//    are always accepted.
//  - Pop happens on out_valid & out_ready. out_valid = !fifo_empty.
//    data_out_1..3 show the FIFO head, driven from registers. Lanes hold
//    while out_valid & !out_ready.
//  - Latency: third sample accepted at edge t -> out_valid=1 with that block
//    after edge t (visible cycle t+1) when the FIFO was empty.
//  - Simultaneous push and pop: occupancy unchanged and order preserved.
//    Push while full cannot happen (s_ready low).
//  - FIFO: circular rd/wr pointers wrap modulo BLK_DEPTH. Count is
//    0..BLK_DEPTH; full means count==BLK_DEPTH.
//  - Samples pass bit-exact; no arithmetic, sign extension or rounding.
//  - Reset mid-operation discards the partial block and all queued blocks.
//    Nothing partial is ever emitted, except via flush.
//  - Block order = arrival order. Lane mapping never rotates.
// CONFIGURATION
//  - DESER_FLUSH_EN defined: adds the flush input.
//    - flush=1 with phase!=0 and FIFO not full pushes the partial block.
//      Unfilled lanes are 0: phase 1 -> {hold1,0,0}; phase 2 -> {hold1,hold2,0}.
//      Phase then returns to 0.
//    - s_ready is forced to 0 in that cycle, so the flush wins over a
//      simultaneous sample.
//    - flush at phase 0, or while the FIFO is full, does nothing.
//  - DESER_FLUSH_EN undefined: there is no flush port. A partial block
//    waits indefinitely for its remaining samples.
// TESTING
//  1. Reset, stream 1..6 back-to-back, out_ready=1 -> blocks (1,2,3) then
//     (4,5,6); each out_valid pulse is 1 cycle after the 3rd/6th accept.
//  2. out_ready=0, offer 1..9 -> (1,2,3),(4,5,6) queued; 7,8 accepted;
//     s_ready=0 holding 9. Raise out_ready -> 9 accepted, order 123,456,789.
//  3. Accept 1,2, assert reset 1 cycle, stream 10,11,12 -> only block
//     (10,11,12) appears; no block containing 1 or 2.
//  4. Stream -32768, 32767, -1 -> lanes 0x8000, 0x7FFF, 0xFFFF exactly.
//  5. Toggle s_valid 1010... over 1..6 with out_ready random -> same blocks
//     as test 1; phase advances only on accepts.
//  6. [DESER_FLUSH_EN] accept 5,6, flush=1 with s_valid=1 (data 7) -> block
//     (5,6,0), 7 not accepted. Flush at phase 0 -> no out_valid.

Source files
------------

// File: rtl/fir_l3_input_deserializer.sv
// Serial-to-3-lane block packer feeding the L=3 parallel FIR, with a small block FIFO.
// Optional partial-block flush input is enabled by defining DESER_FLUSH_EN.
module fir_l3_input_deserializer #(
  parameter int DATA_IN_WIDTH = 16,
  parameter int BLK_DEPTH     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [DATA_IN_WIDTH-1:0] s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic signed [DATA_IN_WIDTH-1:0] data_out_1,
  output logic signed [DATA_IN_WIDTH-1:0] data_out_2,
  output logic signed [DATA_IN_WIDTH-1:0] data_out_3,
  output logic                            out_valid,
`ifdef DESER_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic                            out_ready
);

  localparam int PTR_W = $clog2(BLK_DEPTH);
  localparam int CNT_W = $clog2(BLK_DEPTH + 1);

  typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2} phase_t;

  phase_t                            phase_q, phase_d;
  logic signed [DATA_IN_WIDTH-1:0]   hold1_q, hold1_d;
  logic signed [DATA_IN_WIDTH-1:0]   hold2_q, hold2_d;
  logic signed [DATA_IN_WIDTH-1:0]   mem1_q [BLK_DEPTH];
  logic signed [DATA_IN_WIDTH-1:0]   mem2_q [BLK_DEPTH];
  logic signed [DATA_IN_WIDTH-1:0]   mem3_q [BLK_DEPTH];
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  logic                              full, empty;
  logic                              accept, push, pop, flush_push;
  logic signed [DATA_IN_WIDTH-1:0]   lane2_in, lane3_in;

  assign full  = (cnt_q == CNT_W'(BLK_DEPTH));
  assign empty = (cnt_q == '0);

`ifdef DESER_FLUSH_EN
  // A flush only acts when there is a partial block and room to queue it.
  assign flush_push = flush && (phase_q != PH0) && !full;
`else
  assign flush_push = 1'b0;
`endif

  assign s_ready = ((phase_q != PH2) || !full) && !flush_push;
  assign accept  = s_valid && s_ready;
  assign pop     = !empty && out_ready;
  assign push    = (accept && (phase_q == PH2)) || flush_push;

  // Unfilled lanes of a flushed block are zero; lane 3 takes s_data directly.
  assign lane2_in = (phase_q == PH2) ? hold2_q : '0;
  assign lane3_in = flush_push ? '0 : s_data;

  assign out_valid  = !empty;
  assign data_out_1 = mem1_q[rd_ptr_q];
  assign data_out_2 = mem2_q[rd_ptr_q];
  assign data_out_3 = mem3_q[rd_ptr_q];

  always_comb begin
    phase_d  = phase_q;
    hold1_d  = hold1_q;
    hold2_d  = hold2_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (flush_push) begin
      phase_d = PH0;
    end else if (accept) begin
      case (phase_q)
        PH0:     begin phase_d = PH1; hold1_d = s_data; end
        PH1:     begin phase_d = PH2; hold2_d = s_data; end
        default: phase_d = PH0;
      endcase
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Capture stage: phase/holding registers and block FIFO storage
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH0;
      hold1_q  <= '0;
      hold2_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < BLK_DEPTH; i++) begin
        mem1_q[i] <= '0;
        mem2_q[i] <= '0;
        mem3_q[i] <= '0;
      end
    end else begin
      phase_q  <= phase_d;
      hold1_q  <= hold1_d;
      hold2_q  <= hold2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem1_q[wr_ptr_q] <= hold1_q;
        mem2_q[wr_ptr_q] <= lane2_in;
        mem3_q[wr_ptr_q] <= lane3_in;
      end
    end
  end

endmodule

// File: tb/tb_fir_l3_input_deserializer.sv
// Directed self-checking bench for fir_l3_input_deserializer (flush test under DESER_FLUSH_EN).
module tb_fir_l3_input_deserializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] d1, d2, d3;
  logic        out_valid;
  logic        out_ready;
`ifdef DESER_FLUSH_EN
  logic        flush;
`endif

  int total = 0;
  int bad   = 0;
  int acc_cnt;
  logic [47:0] got[$];
  logic [47:0] expq[$];

  fir_l3_input_deserializer #(.DATA_IN_WIDTH(16), .BLK_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .data_out_1 (d1),
    .data_out_2 (d2),
    .data_out_3 (d3),
    .out_valid  (out_valid),
`ifdef DESER_FLUSH_EN
    .flush      (flush),
`endif
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got.push_back({d1, d2, d3});
      if (s_valid && s_ready) acc_cnt++;
    end
  end

  function automatic logic [47:0] blk(input int a, input int b, input int c);
    logic [15:0] x, y, z;
    x = 16'(a); y = 16'(b); z = 16'(c);
    return {x, y, z};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; out_ready = 1'b0;
`ifdef DESER_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    got = {}; acc_cnt = 0;
  endtask

  task automatic send(input int v);
    s_valid = 1'b1; s_data = 16'(v);
    tick();
  endtask

  task automatic send_wait(input string tag, input int v);
    int n = 0;
    s_valid = 1'b1; s_data = 16'(v);
    while (!s_ready && n < 20) begin tick(); n++; end
    if (n == 20) chk({tag, "_timeout"}, 1, 0);
    else tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    s_valid = 1'b0; out_ready = 1'b1;
    while (out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  task automatic chk_blocks(input string tag);
    chk({tag, "_nblk"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk({tag, "_blk"}, (i < got.size()) ? got[i] : 48'hx, expq[i]);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; out_ready = 1'b0;
`ifdef DESER_FLUSH_EN
    flush = 1'b0;
`endif

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_lanes", {d1, d2, d3}, 48'h0);

    // Test 1: back-to-back stream, consumer always ready
    out_ready = 1'b1;
    send(1); chk("t1_ov_a", out_valid, 0);
    send(2); chk("t1_ov_b", out_valid, 0);
    send(3); chk("t1_ov_c", out_valid, 1);
    chk("t1_blk0_lanes", {d1, d2, d3}, blk(1, 2, 3));
    send(4); chk("t1_ov_d", out_valid, 0);
    send(5);
    send(6); chk("t1_ov_e", out_valid, 1);
    chk("t1_blk1_lanes", {d1, d2, d3}, blk(4, 5, 6));
    s_valid = 1'b0; tick();
    chk("t1_ov_f", out_valid, 0);
    expq = {}; expq.push_back(blk(1, 2, 3)); expq.push_back(blk(4, 5, 6));
    chk_blocks("t1");

    // Test 2: back-pressure fills the FIFO and stalls the third sample of block 3
    do_reset();
    for (int v = 1; v <= 8; v++) send_wait("t2_fill", v);
    s_valid = 1'b1; s_data = 16'd9;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_s_ready", s_ready, 0);
      chk("t2_hold_lanes", {d1, d2, d3}, blk(1, 2, 3));
      tick();
    end
    chk("t2_acc_before", acc_cnt, 8);
    out_ready = 1'b1;
    send_wait("t2_nine", 9);
    drain("t2");
    chk("t2_acc_after", acc_cnt, 9);
    expq = {}; expq.push_back(blk(1, 2, 3)); expq.push_back(blk(4, 5, 6));
    expq.push_back(blk(7, 8, 9));
    chk_blocks("t2");

    // Test 3: reset mid-block discards the partial samples
    do_reset();
    out_ready = 1'b1;
    send(1); send(2);
    do_reset();
    out_ready = 1'b1;
    chk("t3_ov_after_rst", out_valid, 0);
    send(10); send(11); send(12);
    drain("t3");
    expq = {}; expq.push_back(blk(10, 11, 12));
    chk_blocks("t3");

    // Test 4: extreme values pass bit-exact
    do_reset();
    send(-32768); send(32767); send(-1);
    s_valid = 1'b0;
    chk("t4_ov", out_valid, 1);
    chk("t4_lane1", d1, 16'h8000);
    chk("t4_lane2", d2, 16'h7FFF);
    chk("t4_lane3", d3, 16'hFFFF);
    drain("t4");

    // Test 5: gapped source with random consumer readiness
    do_reset();
    for (int v = 1; v <= 6; v++) begin
      out_ready = 1'($urandom_range(0, 1));
      send_wait("t5_send", v);
      s_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("t5");
    chk("t5_acc", acc_cnt, 6);
    expq = {}; expq.push_back(blk(1, 2, 3)); expq.push_back(blk(4, 5, 6));
    chk_blocks("t5");

`ifdef DESER_FLUSH_EN
    // Test 6: flush of a partial block wins over a simultaneous sample
    do_reset();
    send(5); send(6);
    s_valid = 1'b1; s_data = 16'd7; flush = 1'b1;
    chk("t6_s_ready_flush", s_ready, 0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    chk("t6_ov", out_valid, 1);
    chk("t6_lanes", {d1, d2, d3}, blk(5, 6, 0));
    chk("t6_acc", acc_cnt, 2);
    drain("t6");
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_ph0_ov", out_valid, 0);
    expq = {}; expq.push_back(blk(5, 6, 0));
    chk_blocks("t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
